pad_hdx_ctrl: RTL and testbench

PAD_HDX_CTRL -- requirements
Module: pad_hdx_ctrl

---
 rtl/pad_hdx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pad_hdx_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_hdx_ctrl.sv
// Half-duplex single-wire pad controller: transmits a framed byte, optionally
// turns the pad around and receives a framed reply byte with timeout.
module pad_hdx_ctrl #(
    parameter int unsigned BIT_DIV = 4,
    parameter int unsigned TA_CYC  = 2,
    parameter int unsigned RX_TMO  = 255
) (
    input  logic       CLK,
    input  logic       rst_b,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       rx_req,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       err_tmo,
    output logic       err_frm,
    output logic       pad_A,
    output logic       pad_OEN,
    output logic       pad_PEN,
    output logic       pad_UD,
    input  logic       pad_Z
);

    typedef enum logic [2:0] {
        IDLE,
        TX_BIT,
        TURN,
        RX_WAIT,
        RX_BIT,
        DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [7:0]  DIV_MID  = 8'(BIT_DIV / 2);
    localparam logic [15:0] TA_LAST  = 16'(TA_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(RX_TMO - 1);

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_txsh;
    logic        r_rxreq;
    logic [7:0]  r_div;
    logic [3:0]  r_bit;
    logic [15:0] r_cnt;
    logic [7:0]  r_rx;
    logic        r_tmo_flag;
    logic        r_frm_flag;
    logic        r_z1;
    logic        r_zs;
    logic        w_bit_end;
    logic        w_mid;

    assign w_bit_end = (r_div == DIV_LAST);
    assign w_mid     = (r_div == DIV_MID);
    assign rx_data   = r_rx;
    assign pad_PEN   = 1'b1;
    assign pad_UD    = 1'b1;

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b1;
        done    = 1'b0;
        pad_OEN = 1'b0;
        pad_A   = 1'b1;
        err_tmo = 1'b0;
        err_frm = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = TX_BIT;
            end
            TX_BIT: begin
                pad_OEN = 1'b1;
                pad_A   = r_txsh[0];
                if (w_bit_end && r_bit == 4'd9) begin
                    if (!r_rxreq)         w_next = DONE;
                    else if (TA_CYC == 0) w_next = RX_WAIT;
                    else                  w_next = TURN;
                end
            end
            TURN: begin
                if (r_cnt == TA_LAST) w_next = RX_WAIT;
            end
            RX_WAIT: begin
                if (!r_zs)                  w_next = RX_BIT;
                else if (r_cnt == TMO_LAST) w_next = DONE;
            end
            RX_BIT: begin
                // a start bit that reads high at mid-bit was a glitch
                if (w_mid) begin
                    if (r_bit == 4'd0 && r_zs) w_next = RX_WAIT;
                    else if (r_bit == 4'd9)    w_next = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err_tmo = r_tmo_flag;
                err_frm = r_frm_flag;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            r_z1       <= 1'b1;
            r_zs       <= 1'b1;
            r_txsh     <= '1;
            r_rxreq    <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_rx       <= '0;
            r_tmo_flag <= 1'b0;
            r_frm_flag <= 1'b0;
        end else begin
            r_z1 <= pad_Z;
            r_zs <= r_z1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_txsh     <= {1'b1, tx_data, 1'b0};
                        r_rxreq    <= rx_req;
                        r_div      <= '0;
                        r_bit      <= '0;
                        r_tmo_flag <= 1'b0;
                        r_frm_flag <= 1'b0;
                    end
                end
                TX_BIT: begin
                    r_cnt <= '0;
                    if (w_bit_end) begin
                        r_div  <= '0;
                        r_bit  <= r_bit + 4'd1;
                        r_txsh <= {1'b1, r_txsh[9:1]};
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                TURN: begin
                    if (r_cnt == TA_LAST) r_cnt <= '0;
                    else                  r_cnt <= r_cnt + 16'd1;
                end
                RX_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    // the cycle the low level is first seen is cycle 0 of the start bit
                    if (!r_zs) begin
                        r_div <= 8'd1;
                        r_bit <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_tmo_flag <= 1'b1;
                    end
                end
                RX_BIT: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        r_bit <= r_bit + 4'd1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                    if (w_mid) begin
                        if (r_bit >= 4'd1 && r_bit <= 4'd8) r_rx[3'(r_bit - 4'd1)] <= r_zs;
                        if (r_bit == 4'd9) r_frm_flag <= ~r_zs;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pad_hdx_ctrl.sv
// Directed bench for pad_hdx_ctrl: a per-transaction waveform model builds the
// expected output trace, which a negedge compare process checks every cycle.
module tb_pad_hdx_ctrl;

    localparam int BD   = 4;
    localparam int TA   = 2;
    localparam int TMO  = 60;
    localparam int H    = BD / 2;
    localparam int MAXC = 400;

    logic       CLK = 1'b0;
    logic       rst_b, start, rx_req, pad_Z;
    logic [7:0] tx_data, rx_data;
    logic       busy, done, err_tmo, err_frm, pad_A, pad_OEN, pad_PEN, pad_UD;

    pad_hdx_ctrl #(.BIT_DIV(BD), .TA_CYC(TA), .RX_TMO(TMO)) dut (
        .CLK(CLK), .rst_b(rst_b), .start(start), .tx_data(tx_data), .rx_req(rx_req),
        .busy(busy), .rx_data(rx_data), .done(done), .err_tmo(err_tmo), .err_frm(err_frm),
        .pad_A(pad_A), .pad_OEN(pad_OEN), .pad_PEN(pad_PEN), .pad_UD(pad_UD), .pad_Z(pad_Z)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       tmo;
        logic       frm;
        logic       oen;
        logic       a;
        logic [7:0] rx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cmp_e;
    int          total = 0, bad = 0, cyc = 0, done_n = 0, done_cyc = 0, oen_n = 0, acc_cyc = 0;
    logic        last_tmo = 1'b0, last_frm = 1'b0;
    logic [39:0] a_hist = '0;
    logic [7:0]  m_rx = 8'h00;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic t, input logic f,
                                input logic o, input logic a, input logic [7:0] r);
        exp_t e;
        e.busy = b; e.done = d; e.tmo = t; e.frm = f; e.oen = o; e.a = a; e.rx = r;
        return e;
    endfunction

    // one pad_A value per bit period of the most recent 40 driven cycles
    function automatic logic [9:0] a_bits();
        logic [9:0] r;
        for (int k = 0; k < 10; k++) r[k] = a_hist[k*BD];
        return r;
    endfunction

    always @(negedge CLK) begin
        cyc++;
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
            last_tmo = err_tmo;
            last_frm = err_frm;
        end
        if (pad_OEN === 1'b1) begin
            oen_n++;
            a_hist = {pad_A, a_hist[39:1]};
        end
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            chk("busy",    64'(busy),    64'(cmp_e.busy));
            chk("done",    64'(done),    64'(cmp_e.done));
            chk("err_tmo", 64'(err_tmo), 64'(cmp_e.tmo));
            chk("err_frm", 64'(err_frm), 64'(cmp_e.frm));
            chk("pad_OEN", 64'(pad_OEN), 64'(cmp_e.oen));
            chk("pad_A",   64'(pad_A),   64'(cmp_e.a));
            chk("rx_data", 64'(rx_data), 64'(cmp_e.rx));
            chk("pad_PEN", 64'(pad_PEN), 64'h1);
            chk("pad_UD",  64'(pad_UD),  64'h1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0; rst_b = 1'b1; pad_Z = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, m_rx));
        end
    endtask

    // rdly: reply start offset (pad_Z) from RX_WAIT entry, -1 = no reply
    // gl: 1-cycle low pulse offset from RX_WAIT entry, -1 = none
    // ms: TX cycle at which a stray start is raised, -1 = none
    // abrt: reset during data bit 3 of the reply
    task automatic txn(input logic [7:0] d, input logic rq, input int rdly, input logic [7:0] rb,
                       input logic stopv, input int gl, input int ms, input logic abrt);
        logic       zin [0:MAXC];
        logic       zsa [0:MAXC];
        exp_t       ex  [0:MAXC];
        logic [9:0] fr, rf;
        logic [7:0] rx;
        logic       tmo, frm;
        int         w, dn, cnt, c, s, rxs, last;
        fr = {1'b1, d, 1'b0};
        rf = {stopv, rb, 1'b0};
        w = 10*BD + TA;
        rx = m_rx; tmo = 1'b0; frm = 1'b0; rxs = 0; dn = -1;
        for (int i = 0; i <= MAXC; i++) begin
            zin[i] = 1'b1;
            ex[i]  = mk(1, 0, 0, 0, 0, 1, m_rx);
        end
        if (rq && rdly >= 0)
            for (int k = 0; k < 10*BD; k++) zin[w+rdly+k] = rf[k/BD];
        if (rq && gl >= 0) zin[w+gl] = 1'b0;
        for (int i = 0; i <= MAXC; i++) zsa[i] = (i >= 2) ? zin[i-2] : 1'b1;
        for (int i = 0; i < 10*BD; i++) begin
            ex[i].oen = 1'b1;
            ex[i].a   = fr[i/BD];
        end
        if (!rq) begin
            dn = 10*BD;
        end else begin
            cnt = 0; c = w;
            while (dn < 0) begin
                if (!zsa[c]) begin
                    s = c;
                    if (zsa[s+H]) begin
                        cnt++;
                        c = s + H + 1;
                    end else begin
                        rxs = s;
                        for (int j = s; j <= s + 9*BD + H; j++) begin
                            ex[j].rx = rx;
                            for (int i = 0; i < 8; i++)
                                if (j == s + (i+1)*BD + H) rx[i] = zsa[j];
                        end
                        frm = ~zsa[s + 9*BD + H];
                        dn  = s + 9*BD + H + 1;
                    end
                end else if (cnt == TMO - 1) begin
                    tmo = 1'b1;
                    dn  = c + 1;
                end else begin
                    cnt++;
                    c++;
                end
            end
        end
        ex[dn] = mk(1, 1, tmo, frm, 0, 1, rx);
        last = abrt ? rxs + 4*BD + 1 : dn;

        tick();
        start = 1'b1; tx_data = d; rx_req = rq; pad_Z = 1'b1; rst_b = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, m_rx));
        for (int c2 = 0; c2 <= last; c2++) begin
            tick();
            rst_b = 1'b1;
            start = (c2 == ms);
            if (c2 == ms) begin
                tx_data = 8'h0F;
                rx_req  = 1'b1;
            end
            pad_Z = zin[c2];
            if (abrt && c2 == last) begin
                rst_b = 1'b0;
                start = 1'b1;
            end
            exp_q.push_back(ex[c2]);
        end
        if (abrt) begin
            tick();
            rst_b = 1'b1; start = 1'b0; pad_Z = 1'b1;
            m_rx = 8'h00;
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00));
        end else begin
            m_rx = rx;
        end
    endtask

    initial begin : stim
        int d0, o0;
        rst_b = 1'b0; start = 1'b1; tx_data = 8'h00; rx_req = 1'b0; pad_Z = 1'b1;
        tick();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00));
        tick();
        rst_b = 1'b1; start = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00));
        idle(3);
        chk("rst_rx_data", 64'(rx_data), 64'h00);

        // write-only A5
        d0 = done_n; o0 = oen_n;
        txn(8'hA5, 1'b0, -1, 8'h00, 1'b1, -1, -1, 1'b0);
        idle(2);
        chk("wr_bits",   64'(a_bits()), 64'(10'b1101001010));
        chk("wr_oen_n",  64'(oen_n - o0), 64'd40);
        chk("wr_lat",    64'(done_cyc - acc_cyc), 64'd42);
        chk("wr_done_n", 64'(done_n - d0), 64'd1);

        // read 3C, reply 5 cycles after TURN
        txn(8'hC3, 1'b1, 5, 8'h3C, 1'b1, -1, -1, 1'b0);
        idle(2);
        chk("rd_data", 64'(rx_data), 64'h3C);
        chk("rd_tmo",  64'(last_tmo), 64'h0);
        chk("rd_frm",  64'(last_frm), 64'h0);
        chk("rd_lat",  64'(done_cyc - acc_cyc), 64'd90);

        // timeout: 2 + 40 TX + 2 TURN + 60 wait
        txn(8'h11, 1'b1, -1, 8'h00, 1'b1, -1, -1, 1'b0);
        idle(2);
        chk("tmo_flag", 64'(last_tmo), 64'h1);
        chk("tmo_lat",  64'(done_cyc - acc_cyc), 64'd104);
        chk("tmo_data", 64'(rx_data), 64'h3C);

        // glitch then FF with bad stop
        txn(8'h22, 1'b1, 12, 8'hFF, 1'b0, 3, -1, 1'b0);
        idle(2);
        chk("frm_flag", 64'(last_frm), 64'h1);
        chk("frm_tmo",  64'(last_tmo), 64'h0);
        chk("frm_data", 64'(rx_data), 64'hFF);

        // reset in the middle of data bit 3, then a normal write
        d0 = done_n;
        txn(8'h33, 1'b1, 5, 8'h96, 1'b1, -1, -1, 1'b1);
        chk("abrt_data",   64'(rx_data), 64'h00);
        chk("abrt_done_n", 64'(done_n - d0), 64'd0);
        idle(2);
        d0 = done_n;
        txn(8'hA5, 1'b0, -1, 8'h00, 1'b1, -1, -1, 1'b0);
        idle(2);
        chk("post_rst_done_n", 64'(done_n - d0), 64'd1);
        chk("post_rst_bits",   64'(a_bits()), 64'(10'b1101001010));

        // stray start during TX
        d0 = done_n;
        txn(8'h5A, 1'b0, -1, 8'h00, 1'b1, -1, 10, 1'b0);
        idle(3);
        chk("ms_bits",   64'(a_bits()), 64'(10'b1010110100));
        chk("ms_done_n", 64'(done_n - d0), 64'd1);
        chk("ms_lat",    64'(done_cyc - acc_cyc), 64'd42);

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
